clock_reset_sequencer: RTL and testbench



---
 rtl/clock_reset_sequencer_if.sv | 43 ++++
 rtl/clock_reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_clock_reset_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/clock_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// clock_reset_sequencer_if
// Groups the lock/request inputs and the reset/status outputs of the
// clock_reset_sequencer into one bundle.
//   pll_locked      raw PLL lock (asynchronous to clk)
//   soft_reset_req  single-cycle soft reset request from the CPU register block
//   periph_reset    active-high peripheral reset
//   cpu_reset       active-high CPU reset
//   ready           high while the sequencer is in RUN
//   reset_done      one-cycle pulse on entry to RUN
//   lock_loss_count saturating count of lock losses after settle
// Modports: master drives the requests (PLL wrapper / CPU side),
//           slave is the sequencer itself.
// ----------------------------------------------------------------------------
interface clock_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       periph_reset;
    logic       cpu_reset;
    logic       ready;
    logic       reset_done;
    logic [7:0] lock_loss_count;

    modport master (
        output pll_locked,
        output soft_reset_req,
        input  periph_reset,
        input  cpu_reset,
        input  ready,
        input  reset_done,
        input  lock_loss_count
    );

    modport slave (
        input  pll_locked,
        input  soft_reset_req,
        output periph_reset,
        output cpu_reset,
        output ready,
        output reset_done,
        output lock_loss_count
    );
endinterface

// File: rtl/clock_reset_sequencer.sv
// ----------------------------------------------------------------------------
// clock_reset_sequencer
// Brings the SoC out of reset after the PLL locks: synchronises the lock,
// waits for it to stay stable for SETTLE_CYCLES, holds both resets for
// HOLD_CYCLES, releases periph_reset, then releases cpu_reset STAGE_GAP
// cycles later. Lock loss after settle sends everything back into reset and
// is counted; a soft reset request in RUN re-runs the hold/release stages.
// Ports:
//   clk    system clock (PLL 1x output)
//   reset  synchronous, active-high block reset
//   bus    clock_reset_sequencer_if.slave (lock/request in, resets/status out)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// WAIT_LOCK | resets asserted, waiting for synchronised lock
// SETTLE    | lock seen, counting stable-lock cycles
// HOLD      | lock settled, both resets held asserted
// RELEASE   | periph_reset released, waiting STAGE_GAP before CPU release
// RUN       | both resets released, ready high
// ----------------------------------------------------------------------------
module clock_reset_sequencer #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    clock_reset_sequencer_if.slave        bus
);

    localparam int MAX_01  = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_01 > STAGE_GAP) ? MAX_01 : STAGE_GAP;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lock_s1, lock_s2;
    logic             locked_s;

    logic             periph_q, periph_nxt;
    logic             cpu_q, cpu_nxt;
    logic             ready_q, ready_nxt;
    logic             done_q, done_nxt;
    logic [7:0]       llc_q, llc_nxt;

    assign locked_s = lock_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= bus.pll_locked;
            lock_s2 <= lock_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            llc_q    <= 8'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            periph_q <= periph_nxt;
            cpu_q    <= cpu_nxt;
            ready_q  <= ready_nxt;
            done_q   <= done_nxt;
            llc_q    <= llc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        periph_nxt = periph_q;
        cpu_nxt    = cpu_q;
        ready_nxt  = ready_q;
        done_nxt   = 1'b0;
        llc_nxt    = llc_q;

        // Lock loss once settled overrides everything else, including a
        // coincident soft reset request in RUN.
        if ((state == HOLD || state == RELEASE || state == RUN) && !locked_s) begin
            state_nxt  = WAIT_LOCK;
            cnt_nxt    = '0;
            periph_nxt = 1'b1;
            cpu_nxt    = 1'b1;
            ready_nxt  = 1'b0;
            if (llc_q != 8'hFF) begin
                llc_nxt = llc_q + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = '0;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt  = RELEASE;
                        cnt_nxt    = '0;
                        periph_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        cpu_nxt   = 1'b0;
                        ready_nxt = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.soft_reset_req) begin
                        state_nxt  = HOLD;
                        cnt_nxt    = '0;
                        periph_nxt = 1'b1;
                        cpu_nxt    = 1'b1;
                        ready_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt  = WAIT_LOCK;
                    cnt_nxt    = '0;
                    periph_nxt = 1'b1;
                    cpu_nxt    = 1'b1;
                    ready_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.periph_reset    = periph_q;
    assign bus.cpu_reset       = cpu_q;
    assign bus.ready           = ready_q;
    assign bus.reset_done      = done_q;
    assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_clock_reset_sequencer
// Directed bench for clock_reset_sequencer with SETTLE=4, HOLD=3, GAP=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "after En" means just after the n-th edge counted from E0.
// ----------------------------------------------------------------------------
module tb_clock_reset_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    clock_reset_sequencer_if crs_if ();

    clock_reset_sequencer #(
        .SETTLE_CYCLES (4),
        .HOLD_CYCLES   (3),
        .STAGE_GAP     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (crs_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges; the reset-ordering invariant is checked on every one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("cpu_released_before_periph",
                32'(crs_if.periph_reset & ~crs_if.cpu_reset), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        crs_if.pll_locked     = 1'b0;
        crs_if.soft_reset_req = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // From WAIT_LOCK with synchronisers clear: lock, run E0..E11, land in RUN.
    task automatic bring_up();
        crs_if.pll_locked = 1'b1;
        step(12);
    endtask

    initial begin
        crs_if.pll_locked     = 1'b0;
        crs_if.soft_reset_req = 1'b0;

        // 1. reset values and nominal bring-up
        do_reset();
        chk("rst_periph", 32'(crs_if.periph_reset), 1);
        chk("rst_cpu", 32'(crs_if.cpu_reset), 1);
        chk("rst_ready", 32'(crs_if.ready), 0);
        chk("rst_done", 32'(crs_if.reset_done), 0);
        chk("rst_count", 32'(crs_if.lock_loss_count), 0);

        crs_if.pll_locked = 1'b1;
        step(9);                                   // after E8
        chk("t1_periph_E8", 32'(crs_if.periph_reset), 1);
        step(1);                                   // after E9
        chk("t1_periph_E9", 32'(crs_if.periph_reset), 0);
        chk("t1_cpu_E9", 32'(crs_if.cpu_reset), 1);
        step(1);                                   // after E10
        chk("t1_cpu_E10", 32'(crs_if.cpu_reset), 1);
        chk("t1_done_E10", 32'(crs_if.reset_done), 0);
        step(1);                                   // after E11
        chk("t1_cpu_E11", 32'(crs_if.cpu_reset), 0);
        chk("t1_ready_E11", 32'(crs_if.ready), 1);
        chk("t1_done_E11", 32'(crs_if.reset_done), 1);
        step(1);
        chk("t1_done_E12", 32'(crs_if.reset_done), 0);
        chk("t1_ready_E12", 32'(crs_if.ready), 1);
        chk("t1_count", 32'(crs_if.lock_loss_count), 0);

        // 2. lock glitch during settle: low samples at E3..E5, stable from E6
        do_reset();
        crs_if.pll_locked = 1'b1;
        step(3);                                   // after E2
        crs_if.pll_locked = 1'b0;
        step(3);                                   // after E5
        crs_if.pll_locked = 1'b1;
        step(4);                                   // after E9
        chk("t2_periph_E9", 32'(crs_if.periph_reset), 1);
        step(6);                                   // after E15
        chk("t2_periph_E15", 32'(crs_if.periph_reset), 0);
        chk("t2_count", 32'(crs_if.lock_loss_count), 0);
        step(2);                                   // after E17
        chk("t2_cpu_E17", 32'(crs_if.cpu_reset), 0);
        chk("t2_ready_E17", 32'(crs_if.ready), 1);

        // 3. lock loss in RUN, then relock
        crs_if.pll_locked = 1'b0;
        step(2);                                   // after L1
        chk("t3_periph_L1", 32'(crs_if.periph_reset), 0);
        chk("t3_ready_L1", 32'(crs_if.ready), 1);
        step(1);                                   // after L2
        chk("t3_periph_L2", 32'(crs_if.periph_reset), 1);
        chk("t3_cpu_L2", 32'(crs_if.cpu_reset), 1);
        chk("t3_ready_L2", 32'(crs_if.ready), 0);
        chk("t3_count", 32'(crs_if.lock_loss_count), 1);
        crs_if.pll_locked = 1'b1;
        step(10);                                  // after E9
        chk("t3_relock_periph", 32'(crs_if.periph_reset), 0);
        step(2);                                   // after E11
        chk("t3_relock_cpu", 32'(crs_if.cpu_reset), 0);
        chk("t3_relock_done", 32'(crs_if.reset_done), 1);

        // 4. soft reset in RUN; a second request while in HOLD is ignored
        crs_if.soft_reset_req = 1'b1;
        step(1);                                   // after S
        crs_if.soft_reset_req = 1'b0;
        chk("t4_periph_S", 32'(crs_if.periph_reset), 1);
        chk("t4_cpu_S", 32'(crs_if.cpu_reset), 1);
        chk("t4_ready_S", 32'(crs_if.ready), 0);
        step(3);                                   // after S+3
        chk("t4_periph_S3", 32'(crs_if.periph_reset), 0);
        chk("t4_cpu_S3", 32'(crs_if.cpu_reset), 1);
        step(2);                                   // after S+5
        chk("t4_cpu_S5", 32'(crs_if.cpu_reset), 0);
        chk("t4_done_S5", 32'(crs_if.reset_done), 1);
        chk("t4_count", 32'(crs_if.lock_loss_count), 1);

        crs_if.soft_reset_req = 1'b1;
        step(1);                                   // after S, now HOLD
        step(1);                                   // S+1 samples request in HOLD
        crs_if.soft_reset_req = 1'b0;
        step(2);                                   // after S+3
        chk("t4_hold_req_periph", 32'(crs_if.periph_reset), 0);
        step(2);                                   // after S+5
        chk("t4_hold_req_cpu", 32'(crs_if.cpu_reset), 0);

        // 5. soft reset coincident with first low locked_s edge in RUN
        crs_if.pll_locked = 1'b0;
        step(2);                                   // after L1
        crs_if.soft_reset_req = 1'b1;
        step(1);                                   // L2
        crs_if.soft_reset_req = 1'b0;
        chk("t5_periph", 32'(crs_if.periph_reset), 1);
        chk("t5_count", 32'(crs_if.lock_loss_count), 2);
        step(5);
        chk("t5_periph_later", 32'(crs_if.periph_reset), 1);
        chk("t5_count_later", 32'(crs_if.lock_loss_count), 2);

        // 6. 300 lock losses from RUN, count saturates
        for (int i = 0; i < 300; i++) begin
            bring_up();
            crs_if.pll_locked = 1'b0;
            step(3);
            if (i == 251 || i == 252 || i == 253 || i == 299) begin
                chk("t6_count", 32'(crs_if.lock_loss_count), (i + 3 > 255) ? 32'd255 : 32'(i + 3));
            end
        end

        crs_if.pll_locked = 1'b1;
        step(10);                                  // after E9, in RELEASE
        chk("t6_release_periph", 32'(crs_if.periph_reset), 0);
        chk("t6_release_cpu", 32'(crs_if.cpu_reset), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst_periph", 32'(crs_if.periph_reset), 1);
        chk("t6_rst_cpu", 32'(crs_if.cpu_reset), 1);
        chk("t6_rst_ready", 32'(crs_if.ready), 0);
        chk("t6_rst_done", 32'(crs_if.reset_done), 0);
        chk("t6_rst_count", 32'(crs_if.lock_loss_count), 0);
        step(12);                                  // lock still high: full sequence again
        chk("t6_after_rst_ready", 32'(crs_if.ready), 1);
        chk("t6_after_rst_done", 32'(crs_if.reset_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
